// File: rtl/pending_encoder8_3.sv
// Serial priority encoder: drains a multi-hot request vector one bit index per handshake.
// Define ENCODER_RR_EN for a round-robin search order; the default is fixed lowest-index-first.
module pending_encoder8_3 #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy
);

   localparam int W = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] sel_idx;
   logic         sel_found;
   logic         sel_single;
   logic         out_fire;
   int           pos;

   // Search starts at ptr_q and wraps; with ptr_q held at zero this is plain lowest-index-first.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      sel_idx   = '0;
      sel_found = 1'b0;
      pos       = 0;
      for (int i = 0; i < N; i++) begin
         pos = (int'(ptr_q) + i) % N;
         if (!sel_found && pending_q[pos]) begin
            sel_idx   = W'(pos);
            sel_found = 1'b1;
         end
      end
   end

   assign sel_single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
   assign out_fire   = out_valid && out_ready;

   // Output decode depends on registered state only, never on in_* inputs.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: in_ready = 1'b1;
         BUSY: begin
            out_valid = 1'b1;
            out_idx   = sel_idx;
            out_last  = sel_single;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ptr_d     = ptr_q;
      unique case (state_q)
         IDLE: begin
            // An all-zero vector is consumed without leaving IDLE.
            if (in_valid && (in_vec != '0)) begin
               pending_d = in_vec;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (out_fire) begin
               pending_d[sel_idx] = 1'b0;
               if (sel_single) state_d = IDLE;
            end
         end
         default: ;
      endcase
`ifdef ENCODER_RR_EN
      if (out_fire) ptr_d = (int'(sel_idx) == N - 1) ? '0 : sel_idx + W'(1);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
      end
   end

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Self-checking bench for pending_encoder8_3: directed table, hand-written corner sequences,
// and randomized vectors checked against an ordered-index reference model.
module tb_pending_encoder8_3;

   localparam int N = 8;
   localparam int W = $clog2(N);
`ifdef ENCODER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         busy;

   pending_encoder8_3 #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int model_ptr = 0;

   typedef struct {
      logic [N-1:0] vec;
      int           mode;
      int           n_exp;
      int           first_exp;
      int           final_exp;
   } vec_rec_t;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      model_ptr = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Reference order: set bits visited circularly starting from the model pointer.
   task automatic build_expected(input logic [N-1:0] vec, output int q[$]);
      q.delete();
      for (int i = 0; i < N; i++) begin
         int k;
         k = (model_ptr + i) % N;
         if (vec[k]) q.push_back(k);
      end
   endtask

   // mode 0: out_ready always 1; mode 1: toggle 1,0,1,0...; mode 2: random.
   task automatic run_vector(input logic [N-1:0] vec, input int mode,
                             output int n_seen, output int first_idx, output int final_idx);
      int exp_q[$];
      int budget;
      int toggle;
      int cap;
      bit rdy;
      budget = 0;
      while (!in_ready && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      check("wait_in_ready", in_ready, 1);
      build_expected(vec, exp_q);
      in_valid = 1'b1;
      in_vec   = vec;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_vec   = '0;
      n_seen = 0; first_idx = -1; final_idx = -1; toggle = 0; budget = 0;
      while (exp_q.size() > 0 && budget < 200) begin
         check("out_valid", out_valid, 1);
         check("busy", busy, 1);
         check("in_ready_busy", in_ready, 0);
         check("out_idx", out_idx, exp_q[0]);
         check("out_last", out_last, int'(exp_q.size() == 1));
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = (toggle % 2) == 0;
         else                rdy = 1'($urandom_range(0, 1));
         toggle++;
         cap = int'(out_idx);
         out_ready = rdy;
         @(posedge clk); #1;
         budget++;
         if (rdy) begin
            n_seen++;
            if (n_seen == 1) first_idx = cap;
            final_idx = cap;
            if (RR) model_ptr = (exp_q[0] + 1) % N;
            void'(exp_q.pop_front());
         end
      end
      out_ready = 1'b0;
      if (exp_q.size() != 0) check("drain_timeout", 0, 1);
      check("after_out_valid", out_valid, 0);
      check("after_in_ready", in_ready, 1);
      check("after_busy", busy, 0);
   endtask

   vec_rec_t table_v[8];

   initial begin
      int n, f, l;

      #1ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, f, l;
      logic [N-1:0] rv;

      table_v[0] = '{8'h85, 0, 3, 0, 7};
      table_v[1] = '{8'hFF, 1, 8, 0, 7};
      table_v[2] = '{8'h01, 0, 1, 0, 0};
      table_v[3] = '{8'h80, 1, 1, 7, 7};
      table_v[4] = '{8'h42, 0, 2, 1, 6};
      table_v[5] = '{8'h18, 2, 2, 3, 4};
      table_v[6] = '{8'hAA, 1, 4, 1, 7};
      table_v[7] = '{8'h7E, 2, 6, 1, 6};

      do_reset();

      // Directed table, each entry from a fresh reset.
      for (int t = 0; t < 8; t++) begin
         do_reset();
         run_vector(table_v[t].vec, table_v[t].mode, n, f, l);
         check($sformatf("tbl%0d_count", t), n, table_v[t].n_exp);
         check($sformatf("tbl%0d_first", t), f, table_v[t].first_exp);
         check($sformatf("tbl%0d_final", t), l, table_v[t].final_exp);
      end

      // All-zero vector is accepted and dropped.
      do_reset();
      in_valid = 1'b1;
      in_vec   = '0;
      @(posedge clk); #1;
      check("zero_out_valid", out_valid, 0);
      check("zero_in_ready", in_ready, 1);
      check("zero_busy", busy, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("zero_out_valid2", out_valid, 0);

      // Reset asserted mid-vector discards the remaining bit.
      do_reset();
      in_valid = 1'b1;
      in_vec   = 8'h30;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_first_idx", out_idx, 4);
      check("mid_first_last", out_last, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("mid_second_idx", out_idx, 5);
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_idx", out_idx, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_ptr = 0;
      run_vector(8'h02, 0, n, f, l);
      check("post_rst_count", n, 1);
      check("post_rst_idx", f, 1);

      // in_valid held through BUSY: the new vector is taken only once in IDLE.
      do_reset();
      in_valid = 1'b1;
      in_vec   = 8'h03;
      @(posedge clk); #1;
      in_vec    = 8'h40;
      out_ready = 1'b1;
      check("hold_idx0", out_idx, 0);
      @(posedge clk); #1;
      check("hold_idx1", out_idx, 1);
      check("hold_last1", out_last, 1);
      @(posedge clk); #1;
      check("hold_idle_valid", out_valid, 0);
      check("hold_idle_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_vec   = '0;
      check("hold_new_valid", out_valid, 1);
      check("hold_new_idx", out_idx, 6);
      check("hold_new_last", out_last, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold_done_valid", out_valid, 0);
      @(posedge clk); #1;
      check("hold_once_valid", out_valid, 0);

      // Pointer behaviour across vectors.
      do_reset();
      run_vector(8'h01, 0, n, f, l);
      check("ptr_a_idx", f, 0);
      run_vector(8'h03, 0, n, f, l);
      check("ptr_b_first", f, RR ? 1 : 0);
      check("ptr_b_final", l, RR ? 0 : 1);

      // Randomized vectors without intervening reset.
      do_reset();
      for (int r = 0; r < 40; r++) begin
         rv = N'($urandom_range(1, (1 << N) - 1));
         run_vector(rv, 2, n, f, l);
         check("rand_count", n, $countones(rv));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
